fall_edge_gen: RTL

FALL_EDGE_GEN -- requirements
Module: fall_edge_gen

---
 rtl/fall_edge_gen_pkg.sv | 13 +
 rtl/fall_edge_gen_cnt.sv | 29 ++
 rtl/fall_edge_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fall_edge_gen_pkg.sv
// Shared types and default widths for the falling-edge waveform generator.
package fall_edge_gen_pkg;

  localparam int unsigned DEF_CW = 8;
  localparam int unsigned DEF_BW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/fall_edge_gen_cnt.sv
// Loadable down-counter that holds at zero; times the HIGH and LOW phases.
module fall_edge_gen_cnt
  import fall_edge_gen_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fall_edge_gen.sv
// IDLE/HIGH/LOW waveform generator producing one clean falling edge per pulse.
// Optional macro FEG_BURST_EN adds burst_cnt and repeats HIGH/LOW that many times.
module fall_edge_gen
  import fall_edge_gen_pkg::*;
#(
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned BW = DEF_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] high_len,
  input  logic [CW-1:0] low_len,
`ifdef FEG_BURST_EN
  input  logic [BW-1:0] burst_cnt,
`endif
  output logic          D,
  output logic          busy,
  output logic          edge_strobe,
  output logic          done
);

  if (CW < 1 || BW < 1) begin : g_param_check
    $error("fall_edge_gen: CW and BW must be at least 1");
  end

  state_t        state;
  logic [CW-1:0] low_q;
  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_zero;
`ifdef FEG_BURST_EN
  logic [CW-1:0] high_q;
  logic [BW-1:0] bursts_q;
`endif

  // The counter is loaded with len-1 so a phase lasts len cycles; 0 behaves as 1.
  function automatic logic [CW-1:0] phase_load(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      IDLE: if (start && !abort) begin
        cnt_load  = 1'b1;
        cnt_value = phase_load(high_len);
      end
      HIGH: if (!abort && cnt_zero) begin
        cnt_load  = 1'b1;
        cnt_value = phase_load(low_q);
      end
`ifdef FEG_BURST_EN
      LOW: if (!abort && cnt_zero && bursts_q > BW'(1)) begin
        cnt_load  = 1'b1;
        cnt_value = phase_load(high_q);
      end
`endif
      default: ;
    endcase
  end

  fall_edge_gen_cnt #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  // NOTE: the async reset clears only real control/data registers; there is no memory here to reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      D           <= 1'b0;
      busy        <= 1'b0;
      edge_strobe <= 1'b0;
      done        <= 1'b0;
      low_q       <= '0;
`ifdef FEG_BURST_EN
      high_q      <= '0;
      bursts_q    <= '0;
`endif
    end else begin
      edge_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            state <= HIGH;
            D     <= 1'b1;
            busy  <= 1'b1;
            low_q <= low_len;
`ifdef FEG_BURST_EN
            high_q   <= high_len;
            bursts_q <= (burst_cnt == '0) ? BW'(1) : burst_cnt;
`endif
          end
        end
        HIGH: begin
          if (abort) begin
            state       <= IDLE;
            D           <= 1'b0;
            busy        <= 1'b0;
            edge_strobe <= D;
          end else if (cnt_zero) begin
            state       <= LOW;
            D           <= 1'b0;
            edge_strobe <= 1'b1;
          end
        end
        LOW: begin
          if (abort) begin
            state       <= IDLE;
            D           <= 1'b0;
            busy        <= 1'b0;
            edge_strobe <= D;
          end else if (cnt_zero) begin
`ifdef FEG_BURST_EN
            if (bursts_q > BW'(1)) begin
              state    <= HIGH;
              D        <= 1'b1;
              bursts_q <= bursts_q - 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          D     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
